// File: rtl/camera_frame_writer.sv
// Camera raster pixel stream to frame-buffer write port, with burst FIFO and frame tracking.
// Optional ping-pong banking: define CAMERA_FRAME_WRITER_PING_PONG_EN.
`timescale 1ns/1ps
module camera_frame_writer #(
    parameter int unsigned CAMERA_HSIZE   = 64,
    parameter int unsigned CAMERA_VSIZE   = 48,
    parameter int unsigned PIXEL_SIZE     = 8,
    parameter int unsigned BUF_ADDR_WIDTH = 13,
    parameter int unsigned FIFO_DEPTH     = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame_start,
    input  logic                      pix_valid,
    input  logic [PIXEL_SIZE-1:0]     pix_data,
    output logic [BUF_ADDR_WIDTH-1:0] buf_waddr,
    output logic [PIXEL_SIZE-1:0]     buf_wdata,
    output logic                      buf_wvalid,
    input  logic                      buf_wready,
    output logic                      frame_done,
    output logic                      busy,
`ifdef CAMERA_FRAME_WRITER_PING_PONG_EN
    output logic                      wr_bank,
`endif
    output logic                      overflow
);

    localparam int unsigned TOTAL = CAMERA_HSIZE * CAMERA_VSIZE;
    localparam int unsigned CNT_W = $clog2(TOTAL + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d, pix_idx;
    logic [PTR_W:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]          wr_idx;
    logic [BUF_ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [PIXEL_SIZE-1:0]     fifo_data [FIFO_DEPTH];
    logic [BUF_ADDR_WIDTH-1:0] base, push_addr, hold_addr;
    logic [PIXEL_SIZE-1:0]     hold_data;
    logic                      empty, full, take, push, pop;
    logic                      wvalid_q, done_q, done_d;

`ifdef CAMERA_FRAME_WRITER_PING_PONG_EN
    logic bank_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bank_q <= 1'b0;
        else if (done_d)
            bank_q <= ~bank_q;
    end

    assign base    = bank_q ? BUF_ADDR_WIDTH'(TOTAL) : '0;
    assign wr_bank = bank_q;
`else
    assign base = '0;
`endif

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                   (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);

    // Write strobe is combinational from the FIFO head so a pixel reaches the bus one cycle after capture.
    assign pop  = !empty && buf_wready && !wvalid_q;
    assign take = pix_valid && (frame_start || state_q == ACTIVE);
    assign push = take && (frame_start || !full || pop);

    assign pix_idx   = frame_start ? '0 : cnt_q;
    assign push_addr = base + BUF_ADDR_WIDTH'(pix_idx);
    assign wr_idx    = frame_start ? '0 : wr_ptr_q[PTR_W-1:0];

    assign buf_wvalid = pop;
    assign buf_waddr  = pop ? fifo_addr[rd_ptr_q[PTR_W-1:0]] : hold_addr;
    assign buf_wdata  = pop ? fifo_data[rd_ptr_q[PTR_W-1:0]] : hold_data;
    assign busy       = (state_q != IDLE);
    assign frame_done = done_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        // A restart flushes the queue; a pixel arriving with it lands in slot 0.
        if (frame_start) begin
            rd_ptr_d = '0;
            wr_ptr_d = push ? PTR_ONE : '0;
        end
        if (frame_start || state_q == ACTIVE) begin
            cnt_d   = take ? pix_idx + CNT_ONE : pix_idx;
            state_d = (cnt_d == CNT_W'(TOTAL)) ? DRAIN : ACTIVE;
        end else if (state_q == DRAIN && empty) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            wvalid_q  <= 1'b0;
            done_q    <= 1'b0;
            hold_addr <= '0;
            hold_data <= '0;
            overflow  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wvalid_q <= pop;
            done_q   <= done_d;
            if (pop) begin
                hold_addr <= fifo_addr[rd_ptr_q[PTR_W-1:0]];
                hold_data <= fifo_data[rd_ptr_q[PTR_W-1:0]];
            end
            if (take && !push)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_idx] <= push_addr;
            fifo_data[wr_idx] <= pix_data;
        end
    end

endmodule

// File: tb/tb_camera_frame_writer.sv
// Directed bench for camera_frame_writer: depth-8 (A) and depth-2 (B) instances share the pixel stream.
`timescale 1ns/1ps
module tb_camera_frame_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_data = '0;

    logic [12:0] waddr_a, waddr_b;
    logic [7:0]  wdata_a, wdata_b;
    logic        wvalid_a, wvalid_b, wready_a, wready_b;
    logic        done_a, done_b, busy_a, busy_b, ovf_a, ovf_b;
`ifdef CAMERA_FRAME_WRITER_PING_PONG_EN
    logic        bank_a, bank_b;
`endif

    always #5 clk = ~clk;

    camera_frame_writer #(.CAMERA_HSIZE(4), .CAMERA_VSIZE(2), .PIXEL_SIZE(8),
                          .BUF_ADDR_WIDTH(13), .FIFO_DEPTH(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
        .pix_data(pix_data), .buf_waddr(waddr_a), .buf_wdata(wdata_a), .buf_wvalid(wvalid_a),
        .buf_wready(wready_a), .frame_done(done_a), .busy(busy_a),
`ifdef CAMERA_FRAME_WRITER_PING_PONG_EN
        .wr_bank(bank_a),
`endif
        .overflow(ovf_a));

    camera_frame_writer #(.CAMERA_HSIZE(4), .CAMERA_VSIZE(2), .PIXEL_SIZE(8),
                          .BUF_ADDR_WIDTH(13), .FIFO_DEPTH(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
        .pix_data(pix_data), .buf_waddr(waddr_b), .buf_wdata(wdata_b), .buf_wvalid(wvalid_b),
        .buf_wready(wready_b), .frame_done(done_b), .busy(busy_b),
`ifdef CAMERA_FRAME_WRITER_PING_PONG_EN
        .wr_bank(bank_b),
`endif
        .overflow(ovf_b));

    // Buffer model: ready is registered and drops for one cycle after every write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wready_a <= 1'b1;
            wready_b <= 1'b1;
        end else begin
            wready_a <= !wvalid_a;
            wready_b <= !wvalid_b;
        end
    end

    typedef struct packed {
        logic [12:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        int unsigned gap;
        logic [7:0]  first;
        logic [7:0]  b_mask;
        logic        b_ovf;
    } vec_t;

    wr_t qa[$];
    wr_t qb[$];
    wr_t exp_q[$];
    int  n_tests = 0;
    int  n_fail = 0;
    int  ndone_a = 0;
    int  ndone_b = 0;
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_a = 1'b0;
            prev_b = 1'b0;
        end else begin
            if (wvalid_a) begin
                check("a_back_to_back_write", {31'b0, prev_a}, 32'd0);
                qa.push_back('{addr: waddr_a, data: wdata_a});
            end
            if (wvalid_b) begin
                check("b_back_to_back_write", {31'b0, prev_b}, 32'd0);
                qb.push_back('{addr: waddr_b, data: wdata_b});
            end
            prev_a = wvalid_a;
            prev_b = wvalid_b;
            if (done_a) begin
                ndone_a++;
                check("a_busy_at_done", {31'b0, busy_a}, 32'd0);
            end
            if (done_b) begin
                ndone_b++;
                check("b_busy_at_done", {31'b0, busy_b}, 32'd0);
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        frame_start = 1'b0;
        pix_valid = 1'b0;
        repeat (2) @(posedge clk);
        qa.delete();
        qb.delete();
        ndone_a = 0;
        ndone_b = 0;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
    endtask

    task automatic send_pixels(input int unsigned n, input int unsigned gap, input logic [7:0] first);
        for (int unsigned i = 0; i < n; i++) begin
            pix_valid = 1'b1;
            pix_data  = first + 8'(i);
            @(posedge clk);
            #1 pix_valid = 1'b0;
            for (int unsigned g = 1; g < gap; g++) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy_a && !busy_b) break;
        end
        check({name, "_idle_timeout"}, {31'b0, busy_a | busy_b}, 32'd0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input logic [12:0] base, input logic [7:0] first, input logic [7:0] mask);
        for (int unsigned k = 0; k < 8; k++)
            if (mask[k]) exp_q.push_back('{addr: base + 13'(k), data: first + 8'(k)});
    endtask

    task automatic compare_stream(input string name, input bit sel_b);
        wr_t q[$];
        if (sel_b) q = qb;
        else q = qa;
        check({name, "_count"}, 32'(q.size()), 32'(exp_q.size()));
        for (int k = 0; k < q.size() && k < exp_q.size(); k++) begin
            check($sformatf("%s_addr%0d", name, k), 32'(q[k].addr), 32'(exp_q[k].addr));
            check($sformatf("%s_data%0d", name, k), 32'(q[k].data), 32'(exp_q[k].data));
        end
    endtask

    vec_t vecs[3];

    initial begin
        vecs[0] = '{gap: 2, first: 8'h10, b_mask: 8'hFF,        b_ovf: 1'b0};
        vecs[1] = '{gap: 1, first: 8'h20, b_mask: 8'b1010_1111, b_ovf: 1'b1};
        vecs[2] = '{gap: 3, first: 8'h40, b_mask: 8'hFF,        b_ovf: 1'b0};

        #1 rst_n = 1'b0;
        #1;
        check("a_reset_outputs", {7'b0, waddr_a, wdata_a, wvalid_a, done_a, busy_a, ovf_a}, 32'd0);
        check("b_reset_outputs", {7'b0, waddr_b, wdata_b, wvalid_b, done_b, busy_b, ovf_b}, 32'd0);
        @(posedge clk);
        #1;

        // Full frames: paced, back-to-back burst and slow pacing.
        for (int v = 0; v < 3; v++) begin
            do_reset();
            start_frame();
            send_pixels(8, vecs[v].gap, vecs[v].first);
            wait_idle($sformatf("v%0d", v));
            exp_q.delete();
            expect_frame(13'd0, vecs[v].first, 8'hFF);
            compare_stream($sformatf("v%0d_a", v), 1'b0);
            exp_q.delete();
            expect_frame(13'd0, vecs[v].first, vecs[v].b_mask);
            compare_stream($sformatf("v%0d_b", v), 1'b1);
            check($sformatf("v%0d_a_done_count", v), 32'(ndone_a), 32'd1);
            check($sformatf("v%0d_b_done_count", v), 32'(ndone_b), 32'd1);
            check($sformatf("v%0d_a_overflow", v), {31'b0, ovf_a}, 32'd0);
            check($sformatf("v%0d_b_overflow", v), {31'b0, ovf_b}, {31'b0, vecs[v].b_ovf});
        end

        // Abort after 3 pixels: idx 0 written, idx 1 is on the bus at the restart, idx 2 is flushed.
        do_reset();
        start_frame();
        send_pixels(3, 1, 8'hA0);
        start_frame();
        send_pixels(8, 2, 8'h30);
        wait_idle("abort");
        exp_q.delete();
        exp_q.push_back('{addr: 13'd0, data: 8'hA0});
        exp_q.push_back('{addr: 13'd1, data: 8'hA1});
        expect_frame(13'd0, 8'h30, 8'hFF);
        compare_stream("abort_a", 1'b0);
        compare_stream("abort_b", 1'b1);
        check("abort_a_done_count", 32'(ndone_a), 32'd1);
        check("abort_b_done_count", 32'(ndone_b), 32'd1);

        // Reset in DRAIN with four entries still queued in A.
        do_reset();
        start_frame();
        send_pixels(8, 1, 8'h50);
        check("drain_a_written_before_reset", 32'(qa.size()), 32'd4);
        check("drain_a_busy", {31'b0, busy_a}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("drain_a_reset_outputs", {7'b0, waddr_a, wdata_a, wvalid_a, done_a, busy_a, ovf_a}, 32'd0);
        check("drain_b_reset_outputs", {7'b0, waddr_b, wdata_b, wvalid_b, done_b, busy_b, ovf_b}, 32'd0);
        repeat (2) @(posedge clk);
        qa.delete();
        qb.delete();
        ndone_a = 0;
        ndone_b = 0;
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("post_reset_a_writes", 32'(qa.size()), 32'd0);
        check("post_reset_b_writes", 32'(qb.size()), 32'd0);
        check("post_reset_busy", {30'b0, busy_a, busy_b}, 32'd0);
        check("post_reset_done", 32'(ndone_a + ndone_b), 32'd0);
        start_frame();
        send_pixels(8, 2, 8'h60);
        wait_idle("post_reset");
        exp_q.delete();
        expect_frame(13'd0, 8'h60, 8'hFF);
        compare_stream("post_reset_a", 1'b0);

`ifdef CAMERA_FRAME_WRITER_PING_PONG_EN
        do_reset();
        check("pp_bank_reset", {31'b0, bank_a}, 32'd0);
        start_frame();
        send_pixels(8, 2, 8'h70);
        wait_idle("pp_f1");
        check("pp_bank_after_f1", {31'b0, bank_a}, 32'd1);
        start_frame();
        send_pixels(8, 2, 8'h80);
        wait_idle("pp_f2");
        check("pp_bank_after_f2", {31'b0, bank_a}, 32'd0);
        exp_q.delete();
        expect_frame(13'd0, 8'h70, 8'hFF);
        expect_frame(13'd8, 8'h80, 8'hFF);
        compare_stream("pp_a", 1'b0);
        check("pp_done_count", 32'(ndone_a), 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
